// File: rtl/mem_arb2_pkg.sv
// Shared types and constants for the two-master picorv32 memory arbiter.
// Optional watchdog is enabled by defining MEM_ARB2_TIMEOUT_EN.
package mem_arb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb2_pick.sv
// Combinational winner selection between the two masters, optionally
// masking the master whose transaction is completing this cycle.
module mem_arb2_pick
    import mem_arb2_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       mask_en_i,
    input  logic       mask_idx_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    logic [1:0] req;

    for (genvar gi = 0; gi < 2; gi++) begin : g_mask
        assign req[gi] = valid_i[gi] & ~(mask_en_i & (mask_idx_i == 1'(gi)));
    end

    always_comb begin
        grant_valid_o = |req;
        grant_idx_o   = M0;
        if (req == 2'b11) begin
            // Round-robin hands contention to whoever did not finish last.
            grant_idx_o = (FIXED_PRIO != 0) ? M0 : ~last_grant_i;
        end else if (req[M1]) begin
            grant_idx_o = M1;
        end
    end

endmodule

// File: rtl/mem_arb2.sv
// Two-requester arbiter sharing one picorv32-style memory slave port.
// Define MEM_ARB2_TIMEOUT_EN to build the slave-response watchdog.
module mem_arb2
    import mem_arb2_pkg::*;
#(
    parameter int          FIXED_PRIO     = 0,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        err
);

    state_e      state_q;
    logic        last_grant_q;
    logic        gnt0;
    logic        gnt1;
    logic        in_gnt;
    logic        cur_idx;
    logic        cur_valid;
    logic        timeout_hit;
    logic        xfer_done;
    logic        pick_valid;
    logic        pick_idx;
    logic [31:0] rdata_sel;

    // Gating with reset keeps every output quiet while reset is held,
    // even if the state register still shows an abandoned grant.
    assign gnt0      = (state_q == GNT0) && !reset;
    assign gnt1      = (state_q == GNT1) && !reset;
    assign in_gnt    = gnt0 | gnt1;
    assign cur_idx   = gnt1 ? M1 : M0;
    assign cur_valid = (gnt0 & m0_valid) | (gnt1 & m1_valid);

    assign s_valid = cur_valid & ~timeout_hit;
    assign s_instr = (gnt0 & m0_instr) | (gnt1 & m1_instr);
    assign s_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
    assign s_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);
    assign s_wstrb = gnt0 ? m0_wstrb : (gnt1 ? m1_wstrb : '0);

    assign xfer_done = (s_valid & s_ready) | timeout_hit;
    assign rdata_sel = timeout_hit ? TIMEOUT_RDATA : s_rdata;
    assign m0_ready  = gnt0 & xfer_done;
    assign m1_ready  = gnt1 & xfer_done;
    assign m0_rdata  = gnt0 ? rdata_sel : '0;
    assign m1_rdata  = gnt1 ? rdata_sel : '0;

    mem_arb2_pick #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .valid_i      ({m1_valid, m0_valid}),
        .last_grant_i (last_grant_q),
        .mask_en_i    (in_gnt),
        .mask_idx_i   (cur_idx),
        .grant_valid_o(pick_valid),
        .grant_idx_o  (pick_idx)
    );

`ifdef MEM_ARB2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt_q;

    // A same-cycle s_ready takes precedence over the watchdog.
    assign timeout_hit = cur_valid & ~s_ready & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err         = timeout_hit;

    always_ff @(posedge clk) begin
        if (reset || !in_gnt || xfer_done) begin
            tmo_cnt_q <= '0;
        end else if (!s_ready) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= M1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= pick_idx ? GNT1 : GNT0;
                    end
                end
                GNT0, GNT1: begin
                    if (xfer_done) begin
                        last_grant_q <= cur_idx;
                        state_q      <= pick_valid ? (pick_idx ? GNT1 : GNT0) : IDLE;
                    end else if (!cur_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb2.sv
// Scoreboard bench for mem_arb2: a round-robin instance with a latency-programmable
// slave model, plus a FIXED_PRIO=1 instance for the priority scenario.
module tb_mem_arb2;

    typedef struct packed {
        logic        idx;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m0_instr = 1'b0, m1_valid = 1'b0, m1_instr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m1_ready, s_valid, s_instr, s_ready, err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    logic        slave_en = 1'b1;
    int unsigned slave_lat = 1;
    logic        rd_mode = 1'b0;
    logic [31:0] slave_rdata = '0;
    int unsigned s_cnt = 0;

    logic        fp_m0_valid = 1'b0, fp_m1_valid = 1'b0;
    logic [31:0] fp_m0_addr = '0, fp_m1_addr = '0;
    logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr, fp_s_ready, fp_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;
    logic        fp_zero1 = 1'b0;
    logic [31:0] fp_zero32 = '0;
    logic [3:0]  fp_zero4 = '0;
    int unsigned fp_cnt = 0;
    int          fp_viol = 0;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_arb2 #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .err(err)
    );

    mem_arb2 #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_valid(fp_m0_valid), .m0_instr(fp_zero1), .m0_addr(fp_m0_addr), .m0_wdata(fp_zero32),
        .m0_wstrb(fp_zero4), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_valid(fp_m1_valid), .m1_instr(fp_zero1), .m1_addr(fp_m1_addr), .m1_wdata(fp_zero32),
        .m1_wstrb(fp_zero4), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
        .s_wstrb(fp_s_wstrb), .s_ready(fp_s_ready), .s_rdata(fp_zero32), .err(fp_err)
    );

    // Slave models: ready is purely registered (waits slave_lat cycles of s_valid).
    always @(posedge clk) begin
        if (s_valid && !s_ready) s_cnt <= s_cnt + 1;
        else s_cnt <= 0;
        if (fp_s_valid && !fp_s_ready) fp_cnt <= fp_cnt + 1;
        else fp_cnt <= 0;
    end
    assign s_ready    = slave_en && (s_cnt >= slave_lat);
    assign s_rdata    = rd_mode ? {s_addr[15:0], 16'hC0DE} : slave_rdata;
    assign fp_s_ready = (fp_cnt >= 1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic idx, input logic [31:0] rd);
        exp_t e;
        e.idx   = idx;
        e.rdata = rd;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws, input logic ins);
        if (idx == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = ins;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = ins;
        end
    endtask

    // Issues n back-to-back reads from one master, holding valid until each ready.
    task automatic run_master(input int idx, input logic [31:0] base, input int n);
        logic got;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            set_req(idx, 1'b1, base + 32'(4 * k), '0, '0, 1'b0);
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                got = (idx == 0) ? m0_ready : m1_ready;
            end
            if (!got) check($sformatf("m%0d_ready_timeout", idx), 32'(got), 32'd1);
            step();
        end
        set_req(idx, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wait_fp(input int idx, input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = (idx == 0) ? fp_m0_ready : fp_m1_ready;
        end
        check(name, 32'(got), 32'd1);
    endtask

    // Monitor: every ready pops one expected completion.
    always @(negedge clk) begin
        if (!reset && (m0_ready || m1_ready)) begin
            exp_t        e;
            logic [31:0] act_rd;
            tests++;
            act_rd = m1_ready ? m1_rdata : m0_rdata;
            if (m0_ready && m1_ready) begin
                fails++;
                $display("FAIL dual_ready: got both readies required one");
            end else if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ready: got m%0d rdata %h required none", m1_ready, act_rd);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] txn m%0d rdata=%h (expect m%0d rdata=%h)", m1_ready, act_rd, e.idx, e.rdata);
                if (m1_ready !== e.idx || act_rd !== e.rdata) begin
                    fails++;
                    $display("FAIL sb_txn: got m%0d/%h required m%0d/%h", m1_ready, act_rd, e.idx, e.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fp_m0_valid && ((fp_s_valid && fp_s_addr == 32'h700) || fp_m1_ready)) fp_viol++;
    end

    initial begin
        int gaps;
        int rdy_cyc;
        int err_cnt;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {28'd0, s_valid, m0_ready, m1_ready, err}, 32'd0);
        check("rst_addr", s_addr, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        step();
        reset = 1'b0;

        // Round-robin contention from reset: M0, M1, M0, M1 with no bubble
        rd_mode = 1'b1; slave_lat = 1; gaps = 0;
        push_exp(1'b0, 32'h0200C0DE);
        push_exp(1'b1, 32'h0300C0DE);
        push_exp(1'b0, 32'h0204C0DE);
        push_exp(1'b1, 32'h0304C0DE);
        fork
            run_master(0, 32'h200, 2);
            run_master(1, 32'h300, 2);
            begin
                int seen;
                seen = 0;
                @(negedge clk);
                for (int c = 0; c < 40 && seen < 4; c++) begin
                    @(negedge clk);
                    if (!s_valid) gaps++;
                    if (m0_ready || m1_ready) seen++;
                end
            end
        join
        check("rr_no_bubble", 32'(gaps), 32'd0);
        step();

        // Write passthrough from m1
        rd_mode = 1'b0; slave_rdata = 32'h0BAD_F00D;
        push_exp(1'b1, 32'h0BAD_F00D);
        set_req(1, 1'b1, 32'h1000_0000, 32'hA5A5_A5A5, 4'b0110, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("wr_s_valid", 32'(s_valid), 32'd1);
        check("wr_s_addr", s_addr, 32'h1000_0000);
        check("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
        check("wr_s_wstrb", 32'(s_wstrb), 32'h6);
        @(negedge clk);
        check("wr_m1_ready", 32'(m1_ready), 32'd1);
        step();
        set_req(1, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        check("wr_ready_1cyc", 32'(m1_ready), 32'd0);
        step();

        // Single read, slave ready 2 cycles after s_valid
        slave_lat = 2; slave_rdata = 32'h1234_5678;
        push_exp(1'b0, 32'h1234_5678);
        set_req(0, 1'b1, 32'h100, '0, '0, 1'b1);
        @(negedge clk);
        check("rd_req_cycle_svalid", {31'd0, s_valid}, 32'd0);
        @(negedge clk);
        check("rd_grant_svalid", 32'(s_valid), 32'd1);
        check("rd_grant_addr", s_addr, 32'h100);
        check("rd_grant_instr", 32'(s_instr), 32'd1);
        @(negedge clk);
        check("rd_wait_ready", 32'(m0_ready), 32'd0);
        @(negedge clk);
        check("rd_ready", 32'(m0_ready), 32'd1);
        step();
        set_req(0, 1'b0, '0, '0, '0, 1'b0);
        step();

        // Reset while GNT1 is stalled, then both request: M0 first
        slave_en = 1'b0;
        set_req(1, 1'b1, 32'h500, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_gnt1", s_addr, 32'h500);
        step();
        reset = 1'b1;
        set_req(0, 1'b1, 32'h400, '0, '0, 1'b0);
        @(negedge clk);
        check("mid_rst_quiet", {29'd0, s_valid, m0_ready, m1_ready}, 32'd0);
        step();
        @(negedge clk);
        check("mid_rst_quiet2", {29'd0, s_valid, m0_ready, m1_ready}, 32'd0);
        step();
        reset = 1'b0; slave_en = 1'b1; slave_lat = 1; rd_mode = 1'b1;
        push_exp(1'b0, 32'h0400C0DE);
        push_exp(1'b1, 32'h0500C0DE);
        fork
            run_master(0, 32'h400, 1);
            run_master(1, 32'h500, 1);
            begin
                @(negedge clk);
                check("post_rst_idle", 32'(s_valid), 32'd0);
                @(negedge clk);
                check("post_rst_m0_first", s_addr, 32'h400);
            end
        join
        step();

        // Fixed priority instance
        fp_m0_valid = 1'b1; fp_m0_addr = 32'h600;
        wait_fp(0, "fp_solo_m0");
        step();
        fp_m0_valid = 1'b0;
        step();
        fp_m0_valid = 1'b1; fp_m0_addr = 32'h604;
        fp_m1_valid = 1'b1; fp_m1_addr = 32'h700;
        @(negedge clk);
        @(negedge clk);
        check("fp_m0_wins", fp_s_addr, 32'h604);
        wait_fp(0, "fp_m0_ready");
        step();
        fp_m0_valid = 1'b0;
        @(negedge clk);
        check("fp_m1_after_m0", {fp_s_valid, fp_s_addr[30:0]}, 32'h8000_0700);
        wait_fp(1, "fp_m1_ready");
        step();
        fp_m1_valid = 1'b0;
        check("fp_no_m1_while_m0", 32'(fp_viol), 32'd0);
        step();

`ifdef MEM_ARB2_TIMEOUT_EN
        // Watchdog: slave never answers, 8th grant cycle completes with DEADBEEF
        slave_en = 1'b0; rdy_cyc = 0; err_cnt = 0;
        push_exp(1'b0, 32'hDEAD_BEEF);
        set_req(0, 1'b1, 32'h800, '0, '0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (err) err_cnt++;
            if (m0_ready && rdy_cyc == 0) begin
                rdy_cyc = c;
                check("wd_err_with_ready", 32'(err), 32'd1);
                #1;
                set_req(0, 1'b0, '0, '0, '0, 1'b0);
            end
        end
        check("wd_ready_cycle", 32'(rdy_cyc), 32'd8);
        check("wd_err_pulses", 32'(err_cnt), 32'd1);
        slave_en = 1'b1;
`else
        rdy_cyc = 0; err_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (err) err_cnt++;
        end
        check("err_tied_low", 32'(err_cnt + rdy_cyc), 32'd0);
`endif

        step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
